// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time sequencer that fills instruction memory from a
// byte stream before the CPU is released.
//
// Bytes arrive over a valid/ready handshake and are packed little-endian into
// 32-bit words. Each complete word is written once to consecutive word-aligned
// byte addresses starting at 0. cpu_stall stays high until a full program has
// been loaded.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one trailing checksum byte (mod-256 sum of all data bytes)
//   is expected after the last word, and err flags a mismatch.
//   When undefined, there is no checksum state and err is tied low.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       begin a load (honoured in IDLE or DONE only)
//   prog_words  program length in words; 0 or > IMEM_WORDS means IMEM_WORDS
//   byte_in     stream data
//   byte_valid  byte_in valid
//   byte_ready  loader accepts a byte this cycle (decoded from state only)
//   mem_we      instruction memory write strobe, one-cycle pulse
//   mem_addr    write byte address, word-aligned
//   mem_wdata   write data
//   busy        load in progress
//   done        load finished; held until next start or reset
//   err         checksum mismatch
//   cpu_stall   high until a load completes
module imem_boot_loader #(
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  prog_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_stall
);

    localparam int unsigned LEN_W  = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ACC_W  = 24;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    widx_q, widx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [ACC_W-1:0]    word_q, word_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cpu_stall_q, cpu_stall_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic                err_q, err_d;
`endif

    logic [LEN_W-1:0]    len_clamped_c;
    logic [LEN_W-1:0]    widx_inc_c;
    logic                xfer_c;

    // Length clamp keeps the word index strictly below IMEM_WORDS.
    always_comb begin
        if (prog_words == 8'd0 || 32'(prog_words) > IMEM_WORDS) begin
            len_clamped_c = LEN_W'(IMEM_WORDS);
        end else begin
            len_clamped_c = prog_words;
        end
    end

    // byte_ready depends on state only, so there is no input-to-output path.
    always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
`else
        byte_ready = (state_q == S_RECV);
`endif
    end

    assign xfer_c     = byte_valid && byte_ready;
    assign widx_inc_c = widx_q + LEN_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        widx_d      = widx_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        cpu_stall_d = cpu_stall_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        err_d       = err_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RECV;
                    len_d       = len_clamped_c;
                    widx_d      = '0;
                    bcnt_d      = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    cpu_stall_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d      = '0;
                    err_d       = 1'b0;
`endif
                end
            end

            S_RECV: begin
                if (xfer_c) begin
                    // Shift in from the top so byte 0 ends up in bits [7:0].
                    word_d = {byte_in, word_q[ACC_W-1:8]};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q + byte_in;
`endif
                    if (bcnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_W'({widx_q, 2'b00});
                        mem_wdata_d = {byte_in, word_q};
                        state_d     = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                widx_d = widx_inc_c;
                if (widx_inc_c == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d     = S_CHECK;
`else
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cpu_stall_d = 1'b0;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer_c) begin
                    err_d       = (byte_in != csum_q);
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cpu_stall_d = 1'b0;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            widx_q      <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_stall_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_stall_q <= cpu_stall_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cpu_stall = cpu_stall_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: self-checking bench for imem_boot_loader.
// A scoreboard holds the words each load must write (built from the byte
// stream and clamped length); a negedge monitor checks every cycle against it
// plus a few handshake-level timing rules. Directed tests add literal checks.
module tb_imem_boot_loader;

    localparam int unsigned IMEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  prog_words;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_stall;

    imem_boot_loader #(.IMEM_WORDS(IMEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prog_words (prog_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_stall  (cpu_stall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard / model state
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         w;
    int          data_left = 0;
    int          acc       = 0;
    bit          mon_en    = 1'b0;
    bit          exp_we_next  = 1'b0;
    bit          exp_fin      = 1'b0;
    bit          exp_rdy_next = 1'b0;
    bit          prev_rst     = 1'b1;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [31:0] obs_addr [0:255];
    logic [31:0] obs_data [0:255];
    int          obs_cnt = 0;
    logic [7:0]  stim [0:255];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  cs_delta = 8'd0;
`endif

    // Per-cycle monitor; inputs change just after posedge, so negedge is stable.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("stall_vs_done", 32'(cpu_stall), 32'(!done));
            chk("busy_and_done", 32'(busy & done), 32'd0);
            chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
            chk("err_tied_low", 32'(err), 32'd0);
`endif
            chk("we_timing", 32'(mem_we), 32'(exp_we_next));
            if (exp_rdy_next) chk("ready_after_write", 32'(byte_ready), 32'd1);
            if (exp_fin) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk("check_busy", 32'(busy), 32'd1);
                chk("check_not_done", 32'(done), 32'd0);
                chk("check_ready", 32'(byte_ready), 32'd1);
`else
                chk("done_after_last", 32'(done), 32'd1);
                chk("stall_after_last", 32'(cpu_stall), 32'd0);
                chk("busy_after_last", 32'(busy), 32'd0);
`endif
            end
            exp_fin      = 1'b0;
            exp_rdy_next = 1'b0;
            if (mem_we) begin
                chk("ready_low_in_write", 32'(byte_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with no write expected at %0t",
                             mem_addr, mem_wdata, $time);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_wdata, w.data);
                    if (exp_q.size() == 0 && data_left == 0) exp_fin = 1'b1;
                    else exp_rdy_next = 1'b1;
                end
                if (obs_cnt < 256) begin
                    obs_addr[obs_cnt] = mem_addr;
                    obs_data[obs_cnt] = mem_wdata;
                end
                obs_cnt++;
            end else if (!prev_rst) begin
                chk("addr_hold", mem_addr, prev_addr);
                chk("data_hold", mem_wdata, prev_data);
            end
            prev_addr   = mem_addr;
            prev_data   = mem_wdata;
            prev_rst    = rst;
            exp_we_next = 1'b0;
            if (rst) begin
                exp_q.delete();
                data_left = 0;
                acc       = 0;
            end else if (byte_valid && byte_ready && data_left > 0) begin
                acc++;
                data_left--;
                if (acc % 4 == 0) exp_we_next = 1'b1;
            end
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) step();
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
            step();
        end
        byte_valid = 1'b0;
        chk("byte_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_start(input logic [7:0] pw);
        start      = 1'b1;
        prog_words = pw;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk("done_reached", 32'(done), 32'd1);
        step();
    endtask

    // Full load from stim[]: expected writes come from plain arithmetic on stim.
    task automatic load(input logic [7:0] pw, input int gapmode, input int pulse_at);
        int          len;
        logic [31:0] d;
        logic [7:0]  sum;
        len = (pw == 8'd0 || int'(pw) > int'(IMEM_WORDS)) ? int'(IMEM_WORDS) : int'(pw);
        sum = 8'd0;
        for (int wi = 0; wi < len; wi++) begin
            d = 32'(stim[4*wi]) | (32'(stim[4*wi+1]) << 8) |
                (32'(stim[4*wi+2]) << 16) | (32'(stim[4*wi+3]) << 24);
            exp_q.push_back('{addr: 32'(wi * 4), data: d});
            for (int k = 0; k < 4; k++) sum = sum + stim[4*wi+k];
        end
        acc       = 0;
        data_left = 4 * len;
        do_start(pw);
        for (int i = 0; i < 4 * len; i++) begin
            if (i == pulse_at) begin
                start      = 1'b1;
                prog_words = 8'd1;
                step();
                start      = 1'b0;
            end
            send_byte(stim[i], (gapmode != 0) ? (i % 3) : 0);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(sum + cs_delta, 0);
`else
        if (sum == 8'hxx) $display("unreachable");
`endif
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        prog_words = 8'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;

        // Reset / idle
        repeat (5) begin
            @(negedge clk);
            chk("idle_cpu_stall", 32'(cpu_stall), 32'd1);
            chk("idle_byte_ready", 32'(byte_ready), 32'd0);
            chk("idle_mem_we", 32'(mem_we), 32'd0);
            chk("idle_mem_addr", mem_addr, 32'd0);
            chk("idle_mem_wdata", mem_wdata, 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_err", 32'(err), 32'd0);
        end
        step();

        // Two-word load, back-to-back bytes
        stim[0] = 8'h78; stim[1] = 8'h56; stim[2] = 8'h34; stim[3] = 8'h12;
        stim[4] = 8'hEF; stim[5] = 8'hBE; stim[6] = 8'hAD; stim[7] = 8'hDE;
        obs_cnt = 0;
        load(8'd2, 0, -1);
        chk("t1_write_count", 32'(obs_cnt), 32'd2);
        chk("t1_addr0", obs_addr[0], 32'h0000_0000);
        chk("t1_data0", obs_data[0], 32'h1234_5678);
        chk("t1_addr1", obs_addr[1], 32'h0000_0004);
        chk("t1_data1", obs_data[1], 32'hDEAD_BEEF);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_stall", 32'(cpu_stall), 32'd0);

        // prog_words=0 clamps to IMEM_WORDS
        for (int i = 0; i < 256; i++) stim[i] = 8'(i * 7 + 3);
        obs_cnt = 0;
        load(8'd0, 0, -1);
        chk("t3_write_count", 32'(obs_cnt), 32'd64);
        chk("t3_last_addr", obs_addr[63], 32'h0000_00FC);
        chk("t3_done", 32'(done), 32'd1);

        // Gapped stream with a start pulse mid-load
        for (int i = 0; i < 256; i++) stim[i] = 8'(i * 13 + 5);
        obs_cnt = 0;
        load(8'd3, 1, 5);
        chk("t4_write_count", 32'(obs_cnt), 32'd3);

        // Reset after 6 bytes of a 4-word load
        for (int i = 0; i < 256; i++) stim[i] = 8'(i * 3 + 1);
        obs_cnt = 0;
        for (int wi = 0; wi < 4; wi++)
            exp_q.push_back('{addr: 32'(wi * 4),
                              data: 32'(stim[4*wi]) | (32'(stim[4*wi+1]) << 8) |
                                    (32'(stim[4*wi+2]) << 16) | (32'(stim[4*wi+3]) << 24)});
        acc       = 0;
        data_left = 16;
        do_start(8'd4);
        for (int i = 0; i < 6; i++) send_byte(stim[i], 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_byte_ready", 32'(byte_ready), 32'd0);
        chk("t5_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        chk("t5_write_count", 32'(obs_cnt), 32'd1);
        step();
        obs_cnt = 0;
        load(8'd1, 0, -1);
        chk("t5_reload_count", 32'(obs_cnt), 32'd1);
        chk("t5_reload_addr", obs_addr[0], 32'h0000_0000);
        chk("t5_reload_data", obs_data[0], 32'h0A07_0401);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum: 01+02+03+04 = 0x0A
        stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04;
        cs_delta = 8'd0;
        load(8'd1, 0, -1);
        chk("cs_good_err", 32'(err), 32'd0);
        chk("cs_good_done", 32'(done), 32'd1);
        cs_delta = 8'd1;
        load(8'd1, 0, -1);
        chk("cs_bad_err", 32'(err), 32'd1);
        chk("cs_bad_done", 32'(done), 32'd1);
        do_start(8'd1);
        @(negedge clk);
        chk("cs_start_clears_err", 32'(err), 32'd0);
        chk("cs_start_busy", 32'(busy), 32'd1);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
